seccpu_port_responder: RTL and testbench

Data-port responder for the secure CPU's Harvard data bus. It decodes `data_address` with `read_strobe`/`write_strobe`, serves a word-addressed data RAM plus a small peripheral register file, and drives the CPU's `intr` input from a down-counting timer and a bus-error detector. It sits between the CPU data port and on-chip data storage and is the only interrupt source at top level.

---
 rtl/seccpu_port_pkg.sv | 35 +++
 rtl/seccpu_port_timer.sv | 41 ++++
 rtl/seccpu_port_responder.sv | 131 +++++++++++++
 tb/tb_seccpu_port_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seccpu_port_pkg.sv
// Shared constants for the secure CPU data-port responder: register map,
// CTRL/STATUS bit positions and the default ID word.
package seccpu_port_pkg;

   localparam logic [8:0] ADDR_CTRL    = 9'h1F0;
   localparam logic [8:0] ADDR_TLOAD   = 9'h1F1;
   localparam logic [8:0] ADDR_TCOUNT  = 9'h1F2;
   localparam logic [8:0] ADDR_STATUS  = 9'h1F3;
   localparam logic [8:0] ADDR_SCRATCH = 9'h1F4;
   localparam logic [8:0] ADDR_ERRADDR = 9'h1F5;
   localparam logic [8:0] ADDR_ID      = 9'h1F7;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_AR  = 1;
   localparam int CTRL_TIE = 2;
   localparam int CTRL_BIE = 3;

   localparam int STAT_TEV  = 0;
   localparam int STAT_BERR = 1;

   localparam logic [15:0] ID_DEFAULT = 16'h5EC1;

   typedef enum logic [3:0] {
      SEL_UNMAPPED,
      SEL_RAM,
      SEL_CTRL,
      SEL_TLOAD,
      SEL_TCOUNT,
      SEL_STATUS,
      SEL_SCRATCH,
      SEL_ERRADDR,
      SEL_ID
   } port_sel_e;

endpackage

// File: rtl/seccpu_port_timer.sv
// Down-counting timer: loads on an EN rising write, steps once per enabled
// cycle, and flags expiry (plus EN auto-clear when not auto-reloading).
module seccpu_port_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             ar,
   input  logic [WIDTH-1:0] load_value,
   input  logic             en_rise,
   input  logic             en_clear_wr,
   output logic [WIDTH-1:0] count,
   output logic             expire,
   output logic             en_auto_clear
);

   logic [WIDTH-1:0] count_reg;
   logic             step;

   // A software write clearing EN beats a coincident expiry.
   assign step          = en && !en_clear_wr;
   assign expire        = step && (count_reg == '0);
   assign en_auto_clear = expire && !ar;
   assign count         = count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (en_rise) begin
         count_reg <= load_value;
      end else if (step) begin
         if (count_reg == '0) begin
            if (ar) count_reg <= load_value;
         end else begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

endmodule

// File: rtl/seccpu_port_responder.sv
// Data-port responder: word RAM plus peripheral registers (timer, status,
// scratch, error capture, ID) and the CPU interrupt request.
module seccpu_port_responder
   import seccpu_port_pkg::*;
#(
   parameter int                    DATA_DEPTH = 9,
   parameter int                    DATA_WIDTH = 16,
   parameter int                    RAM_WORDS  = 256,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE   = ID_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_DEPTH-1:0] data_address,
   input  logic                  read_strobe,
   input  logic                  write_strobe,
   input  logic [DATA_WIDTH-1:0] data_wr,
   output logic [DATA_WIDTH-1:0] data_rd,
   output logic                  intr
);

   localparam int                    RAM_AW    = $clog2(RAM_WORDS);
   localparam logic [DATA_DEPTH-1:0] RAM_LIMIT = DATA_DEPTH'(RAM_WORDS);

   port_sel_e             sel;
   logic [RAM_AW-1:0]     ram_idx;
   logic                  rd_ok, wr_ok, berr_set, ctrl_wr, status_wr;
   logic                  en_rise, en_clear_wr, tev_set, en_auto_clear;
   logic [3:0]            ctrl_reg, ctrl_next;
   logic [1:0]            status_reg, status_next;
   logic [DATA_WIDTH-1:0] tload_reg, scratch_reg, erraddr_reg, tcount;
   logic [DATA_WIDTH-1:0] reg_rdata, data_rd_reg;
   logic                  intr_reg;
   logic [DATA_WIDTH-1:0] ram [RAM_WORDS];

   always_comb begin
      sel = SEL_UNMAPPED;
      if (data_address < RAM_LIMIT) begin
         sel = SEL_RAM;
      end else begin
         case (data_address)
            DATA_DEPTH'(ADDR_CTRL):    sel = SEL_CTRL;
            DATA_DEPTH'(ADDR_TLOAD):   sel = SEL_TLOAD;
            DATA_DEPTH'(ADDR_TCOUNT):  sel = SEL_TCOUNT;
            DATA_DEPTH'(ADDR_STATUS):  sel = SEL_STATUS;
            DATA_DEPTH'(ADDR_SCRATCH): sel = SEL_SCRATCH;
            DATA_DEPTH'(ADDR_ERRADDR): sel = SEL_ERRADDR;
            DATA_DEPTH'(ADDR_ID):      sel = SEL_ID;
            default:                   sel = SEL_UNMAPPED;
         endcase
      end
   end

   // Simultaneous read and write is a protocol error: neither side is served.
   assign ram_idx   = data_address[RAM_AW-1:0];
   assign rd_ok     = read_strobe && !write_strobe;
   assign wr_ok     = write_strobe && !read_strobe && (sel != SEL_UNMAPPED);
   assign berr_set  = (read_strobe || write_strobe) &&
                      ((sel == SEL_UNMAPPED) || (read_strobe && write_strobe));
   assign ctrl_wr   = wr_ok && (sel == SEL_CTRL);
   assign status_wr = wr_ok && (sel == SEL_STATUS);
   assign en_rise     = ctrl_wr && data_wr[CTRL_EN] && !ctrl_reg[CTRL_EN];
   assign en_clear_wr = ctrl_wr && !data_wr[CTRL_EN];

   seccpu_port_timer #(.WIDTH(DATA_WIDTH)) u_timer (
      .clk           (clk),
      .reset         (reset),
      .en            (ctrl_reg[CTRL_EN]),
      .ar            (ctrl_reg[CTRL_AR]),
      .load_value    (tload_reg),
      .en_rise       (en_rise),
      .en_clear_wr   (en_clear_wr),
      .count         (tcount),
      .expire        (tev_set),
      .en_auto_clear (en_auto_clear)
   );

   always_comb begin
      ctrl_next = ctrl_reg;
      if (ctrl_wr) ctrl_next = data_wr[3:0];
      else if (en_auto_clear) ctrl_next[CTRL_EN] = 1'b0;
      // Hardware sets are OR-ed in after the clear so they win.
      status_next = status_reg & ~(status_wr ? data_wr[1:0] : 2'b00);
      if (tev_set)  status_next[STAT_TEV]  = 1'b1;
      if (berr_set) status_next[STAT_BERR] = 1'b1;
   end

   always_comb begin
      reg_rdata = '0;
      case (sel)
         SEL_CTRL:    reg_rdata[3:0] = ctrl_reg;
         SEL_TLOAD:   reg_rdata      = tload_reg;
         SEL_TCOUNT:  reg_rdata      = tcount;
         SEL_STATUS:  reg_rdata[1:0] = status_reg;
         SEL_SCRATCH: reg_rdata      = scratch_reg;
         SEL_ERRADDR: reg_rdata      = erraddr_reg;
         SEL_ID:      reg_rdata      = ID_VALUE;
         default:     reg_rdata      = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_ok && (sel == SEL_RAM)) ram[ram_idx] <= data_wr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_reg    <= '0;
         tload_reg   <= '1;
         status_reg  <= '0;
         scratch_reg <= '0;
         erraddr_reg <= '0;
         data_rd_reg <= '0;
         intr_reg    <= 1'b0;
      end else begin
         ctrl_reg   <= ctrl_next;
         status_reg <= status_next;
         intr_reg   <= (status_reg[STAT_TEV]  & ctrl_reg[CTRL_TIE]) |
                       (status_reg[STAT_BERR] & ctrl_reg[CTRL_BIE]);
         if (wr_ok && (sel == SEL_TLOAD))   tload_reg   <= data_wr;
         if (wr_ok && (sel == SEL_SCRATCH)) scratch_reg <= data_wr;
         if (berr_set && !status_reg[STAT_BERR])
            erraddr_reg <= DATA_WIDTH'(data_address);
         if (rd_ok)
            data_rd_reg <= (sel == SEL_RAM) ? ram[ram_idx] : reg_rdata;
      end
   end

   assign data_rd = data_rd_reg;
   assign intr    = intr_reg;

endmodule

// File: tb/tb_seccpu_port_responder.sv
// Directed plus randomized bench for seccpu_port_responder, checked against
// a transaction-level model of the register map, timer and bus-error rules.
module tb_seccpu_port_responder;

   localparam logic [8:0] A_CTRL = 9'h1F0, A_TLOAD = 9'h1F1, A_TCOUNT = 9'h1F2;
   localparam logic [8:0] A_STATUS = 9'h1F3, A_ERRADDR = 9'h1F5, A_ID = 9'h1F7;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [8:0]  data_address = '0;
   logic        read_strobe = 1'b0;
   logic        write_strobe = 1'b0;
   logic [15:0] data_wr = '0;
   logic [15:0] data_rd;
   logic        intr;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   seccpu_port_responder dut (
      .clk          (clk),
      .reset        (reset),
      .data_address (data_address),
      .read_strobe  (read_strobe),
      .write_strobe (write_strobe),
      .data_wr      (data_wr),
      .data_rd      (data_rd),
      .intr         (intr)
   );

   // Reference model state
   logic [15:0] m_ram [256];
   logic [3:0]  m_ctrl;
   logic [15:0] m_tload, m_tcount, m_scratch, m_erraddr, m_drd;
   logic [1:0]  m_status;
   logic        m_intr;

   function automatic bit is_mapped(input logic [8:0] a);
      return (a < 9'd256) || ((a >= 9'h1F0) && (a <= 9'h1F7) && (a != 9'h1F6));
   endfunction

   function automatic logic [15:0] m_read(input logic [8:0] a);
      if (a < 9'd256) return m_ram[a[7:0]];
      case (a)
         A_CTRL:    return {12'd0, m_ctrl};
         A_TLOAD:   return m_tload;
         A_TCOUNT:  return m_tcount;
         A_STATUS:  return {14'd0, m_status};
         9'h1F4:    return m_scratch;
         A_ERRADDR: return m_erraddr;
         A_ID:      return 16'h5EC1;
         default:   return 16'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_ctrl = '0; m_tload = 16'hFFFF; m_tcount = '0; m_scratch = '0;
      m_erraddr = '0; m_drd = '0; m_status = '0; m_intr = 1'b0;
   endtask

   task automatic model_step(input bit rd, input bit wr, input logic [8:0] a,
                             input logic [15:0] d);
      bit mapped, wr_ok, berr, ctrl_wr, running, tev;
      logic [3:0]  n_ctrl;
      logic [15:0] n_cnt;
      logic [1:0]  n_st;
      mapped  = is_mapped(a);
      wr_ok   = wr && !rd && mapped;
      berr    = (rd || wr) && (!mapped || (rd && wr));
      ctrl_wr = wr_ok && (a == A_CTRL);
      n_ctrl  = m_ctrl;
      n_cnt   = m_tcount;
      n_st    = m_status;
      tev     = 1'b0;
      if (ctrl_wr) n_ctrl = d[3:0];
      running = m_ctrl[0] && !(ctrl_wr && !d[0]);
      if (running) begin
         if (m_tcount == 16'd0) begin
            tev = 1'b1;
            if (m_ctrl[1]) n_cnt = m_tload;
            else if (!ctrl_wr) n_ctrl[0] = 1'b0;
         end else begin
            n_cnt = m_tcount - 16'd1;
         end
      end
      if (ctrl_wr && d[0] && !m_ctrl[0]) n_cnt = m_tload;
      if (wr_ok && (a == A_STATUS)) n_st = n_st & ~d[1:0];
      if (tev)  n_st[0] = 1'b1;
      if (berr) n_st[1] = 1'b1;
      m_intr = (m_status[0] & m_ctrl[2]) | (m_status[1] & m_ctrl[3]);
      if (rd && !wr) m_drd = mapped ? m_read(a) : 16'd0;
      if (berr && !m_status[1]) m_erraddr = {7'd0, a};
      if (wr_ok && (a < 9'd256)) m_ram[a[7:0]] = d;
      if (wr_ok && (a == A_TLOAD)) m_tload = d;
      if (wr_ok && (a == 9'h1F4)) m_scratch = d;
      m_ctrl = n_ctrl; m_tcount = n_cnt; m_status = n_st;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus(input bit rd, input bit wr, input logic [8:0] a, input logic [15:0] d);
      @(negedge clk);
      read_strobe = rd; write_strobe = wr; data_address = a; data_wr = d;
      @(posedge clk);
      model_step(rd, wr, a, d);
      #1;
      check("data_rd", data_rd, m_drd);
      check("intr", {15'd0, intr}, {15'd0, m_intr});
   endtask

   task automatic rd_(input logic [8:0] a);  bus(1'b1, 1'b0, a, 16'd0); endtask
   task automatic wr_(input logic [8:0] a, input logic [15:0] d); bus(1'b0, 1'b1, a, d); endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 9'd0, 16'd0);
   endtask

   initial begin
      logic [15:0] seq [5];
      int r, k;
      logic [8:0]  a;
      logic [15:0] d;
      bit rd, wr;
      seq = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd3};
      for (int i = 0; i < 256; i++) m_ram[i] = 16'd0;
      model_reset();
      #1;
      check("reset_data_rd", data_rd, 16'd0);
      check("reset_intr", {15'd0, intr}, 16'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // RAM and ID
      wr_(9'h010, 16'h1234);
      rd_(9'h010);
      check("ram_rd", data_rd, 16'h1234);
      rd_(A_ID);
      check("id", data_rd, 16'h5EC1);
      rd_(A_TLOAD);
      check("tload_reset", data_rd, 16'hFFFF);

      // Auto-reload timer, period TLOAD+1
      wr_(A_TLOAD, 16'd3);
      wr_(A_CTRL, 16'h0007);
      for (int i = 0; i < 5; i++) begin
         rd_(A_TCOUNT);
         check("tcount_seq", data_rd, seq[i]);
      end
      check("tev_intr", {15'd0, intr}, 16'd1);
      wr_(A_STATUS, 16'h0001);
      idle(1);
      check("intr_cleared", {15'd0, intr}, 16'd0);
      wr_(A_CTRL, 16'h0000);
      wr_(A_STATUS, 16'h0003);

      // One-shot
      wr_(A_TLOAD, 16'd2);
      wr_(A_CTRL, 16'h0005);
      idle(3);
      rd_(A_STATUS);
      check("oneshot_tev", data_rd, 16'h0001);
      rd_(A_CTRL);
      check("oneshot_en_off", data_rd, 16'h0004);
      rd_(A_TCOUNT);
      check("oneshot_hold", data_rd, 16'h0000);
      wr_(A_STATUS, 16'h0003);

      // Bus errors
      wr_(A_CTRL, 16'h0008);
      rd_(9'h150);
      check("unmapped_rd", data_rd, 16'h0000);
      idle(1);
      check("berr_intr", {15'd0, intr}, 16'd1);
      rd_(9'h160);
      rd_(A_ERRADDR);
      check("erraddr_first", data_rd, 16'h0150);
      rd_(9'h010);
      bus(1'b1, 1'b1, 9'h010, 16'hDEAD);
      check("conflict_hold", data_rd, 16'h1234);
      rd_(9'h010);
      check("conflict_ram", data_rd, 16'h1234);
      wr_(A_STATUS, 16'h0003);

      // W1C coincident with expiry: set wins
      wr_(A_TLOAD, 16'd3);
      wr_(A_CTRL, 16'h0003);
      idle(3);
      wr_(A_STATUS, 16'h0001);
      rd_(A_STATUS);
      check("w1c_vs_set", data_rd, 16'h0001);
      wr_(A_CTRL, 16'h0000);
      wr_(A_STATUS, 16'h0003);

      // Asynchronous reset mid-count
      wr_(A_TLOAD, 16'd2);
      wr_(A_CTRL, 16'h0007);
      idle(4);
      rd_(A_ID);
      @(negedge clk);
      read_strobe = 1'b0; write_strobe = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("async_rst_data_rd", data_rd, 16'd0);
      check("async_rst_intr", {15'd0, intr}, 16'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      rd_(A_TCOUNT);
      check("rst_tcount", data_rd, 16'd0);
      rd_(A_CTRL);
      check("rst_ctrl", data_rd, 16'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 256; i++) wr_(9'(i), 16'($urandom));
      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 99);
         rd = (r < 45) || (r >= 90 && r < 93);
         wr = (r >= 45 && r < 93);
         k = $urandom_range(0, 9);
         if (k < 4)      a = 9'($urandom_range(0, 255));
         else if (k < 9) a = 9'h1F0 + 9'($urandom_range(0, 7));
         else            a = (k == 9 && $urandom_range(0, 1) == 1) ? 9'h1F6
                                                                   : 9'($urandom_range(256, 495));
         d = 16'($urandom);
         if (a == A_TLOAD) d = 16'($urandom_range(0, 6));
         bus(rd, wr, a, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
